// File: rtl/spike_aer_tx.sv
// Output-FIFO drain and 4-phase AER transmitter with transfer/drop statistics.
// Define SPIKE_AER_NEURON_COUNT_EN to add per-neuron spike counters (cnt_sel/cnt_value).
module spike_aer_tx #(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_empty,
    output logic              fifo_ren,
    input  logic [ADDR_W-1:0] fifo_dout,
    output logic              aer_req,
    output logic [ADDR_W-1:0] aer_addr,
    input  logic              aer_ack,
    output logic              busy,
    output logic [15:0]       sent_count,
    output logic [7:0]        drop_count
`ifdef SPIKE_AER_NEURON_COUNT_EN
    ,
    input  logic [ADDR_W-1:0] cnt_sel,
    output logic [CNT_W-1:0]  cnt_value
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_REQ,
        S_RELEASE,
        S_DROP
    } state_t;

    state_t            state_q;
    logic              fifo_ren_q;
    logic              aer_req_q;
    logic [ADDR_W-1:0] aer_addr_q;
    logic              busy_q;
    logic [15:0]       sent_q;
    logic [7:0]        drop_q;
    logic [7:0]        timer_q;
    logic [7:0]        timer_d;
    logic              timer_done;
    logic              ack_meta_q;
    logic              ack_s_q;

    assign timer_d    = timer_q + 8'd1;
    assign timer_done = (timer_q == 8'(TIMEOUT - 1));

    // aer_ack comes from off-chip; only ack_s_q is ever looked at by the FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            ack_meta_q <= aer_ack;
            ack_s_q    <= ack_meta_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fifo_ren_q <= 1'b0;
            aer_req_q  <= 1'b0;
            aer_addr_q <= '0;
            busy_q     <= 1'b0;
            sent_q     <= 16'd0;
            drop_q     <= 8'd0;
            timer_q    <= 8'd0;
        end else begin
            fifo_ren_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (enable && !fifo_empty) begin
                        state_q    <= S_READ;
                        fifo_ren_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                S_READ: begin
                    state_q <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    aer_addr_q <= fifo_dout;
                    aer_req_q  <= 1'b1;
                    timer_q    <= 8'd0;
                    state_q    <= S_REQ;
                end
                S_REQ: begin
                    // A stale high ack on entry is accepted as a real one.
                    if (ack_s_q) begin
                        aer_req_q <= 1'b0;
                        timer_q   <= 8'd0;
                        state_q   <= S_RELEASE;
                    end else if (timer_done) begin
                        aer_req_q <= 1'b0;
                        state_q   <= S_DROP;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                S_RELEASE: begin
                    if (!ack_s_q) begin
                        sent_q  <= sent_q + 16'd1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (timer_done) begin
                        state_q <= S_DROP;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                S_DROP: begin
                    if (drop_q != 8'hFF) begin
                        drop_q <= drop_q + 8'd1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    aer_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign fifo_ren   = fifo_ren_q;
    assign aer_req    = aer_req_q;
    assign aer_addr   = aer_addr_q;
    assign busy       = busy_q;
    assign sent_count = sent_q;
    assign drop_count = drop_q;

`ifdef SPIKE_AER_NEURON_COUNT_EN
    localparam int NUM_NEURONS = 1 << ADDR_W;

    logic [CNT_W-1:0] cnt_q [NUM_NEURONS];
    logic             cnt_hit;

    // A neuron is counted once its request has been acknowledged.
    assign cnt_hit = (state_q == S_REQ) && ack_s_q;

    for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_cnt
        always_ff @(posedge clock) begin
            if (reset) begin
                cnt_q[gi] <= '0;
            end else if (cnt_hit && (aer_addr_q == ADDR_W'(gi)) &&
                         (cnt_q[gi] != {CNT_W{1'b1}})) begin
                cnt_q[gi] <= cnt_q[gi] + 1'b1;
            end
        end
    end

    assign cnt_value = cnt_q[cnt_sel];
`endif

endmodule
